// File: rtl/add_mul_pp_acc_seq_if.sv
// rtl/add_mul_pp_acc_seq_if.sv - operation/result handshake bundle for the partial-product accumulator
//
// Purpose: groups the operation input stream and the result output stream of
// add_mul_pp_acc_seq.
// Signals:
//   in_valid  : pp holds a valid operation
//   in_ready  : accumulator accepts an operation on this edge
//   pp        : packed rows, row i at [i*widthP +: widthP]
//   out_valid : p holds a finished result
//   out_ready : consumer takes p on this edge
//   p         : product, sum of all rows mod 2^widthP
//   busy      : accumulator is working on or holding an operation
// Modports: master = producer/consumer side, slave = accumulator side.

interface add_mul_pp_acc_seq_if #(
  parameter int widthX = 8,
  parameter int widthY = 8
);
  localparam int widthP = widthX + widthY;

  logic                      in_valid;
  logic                      in_ready;
  logic [widthX*widthP-1:0]  pp;
  logic                      out_valid;
  logic                      out_ready;
  logic [widthP-1:0]         p;
  logic                      busy;

  modport master (
    output in_valid, pp, out_ready,
    input  in_ready, out_valid, p, busy
  );

  modport slave (
    input  in_valid, pp, out_ready,
    output in_ready, out_valid, p, busy
  );
endinterface

// File: rtl/add_mul_pp_acc_seq.sv
// rtl/add_mul_pp_acc_seq.sv - sequential partial-product accumulator for the unsigned adder-multiplier
//
// Purpose: captures one packed partial-product vector per operation and sums
// its widthX rows, rowsPerCycle rows per clock, into a widthP-bit product.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset; drops any operation in flight
//   bus : add_mul_pp_acc_seq_if.slave (in_valid/in_ready/pp, out_valid/out_ready/p, busy)
// Latency is G = ceil(widthX/rowsPerCycle) cycles from acceptance to out_valid;
// back-to-back throughput is one result per G+1 cycles.

module add_mul_pp_acc_seq #(
  parameter int widthX       = 8,
  parameter int widthY       = 8,
  parameter int rowsPerCycle = 2
) (
  input  logic               clk,
  input  logic               rst,
  add_mul_pp_acc_seq_if.slave bus
);
  localparam int widthP = widthX + widthY;
  localparam int G      = (widthX + rowsPerCycle - 1) / rowsPerCycle;
  localparam int CW     = (G > 1) ? $clog2(G) : 1;

  generate
    if (rowsPerCycle < 1 || rowsPerCycle > widthX) begin : g_bad_rows
      $error("add_mul_pp_acc_seq: rowsPerCycle must be in 1..widthX");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state;
  state_t                   state_nx;
  logic [widthX*widthP-1:0] rows;
  logic [widthP-1:0]        acc;
  logic [widthP-1:0]        grp_sum;
  logic [CW-1:0]            cnt;
  logic                     last_grp;
  logic                     take;

  assign last_grp = (cnt == CW'(G - 1));
  // in_ready is only high in IDLE or in DONE with out_ready, so a capture
  // never collides with an accumulation step.
  assign take     = bus.in_valid && bus.in_ready;
  assign bus.p    = acc;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.in_valid) state_nx = ACC;
      ACC:  if (last_grp) state_nx = DONE;
      DONE: begin
        // Result hand-off and new capture may share one edge.
        if (bus.out_ready) state_nx = bus.in_valid ? ACC : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output decode: state only, except DONE in_ready follows out_ready.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state)
      IDLE: bus.in_ready = 1'b1;
      ACC:  bus.busy = 1'b1;
      DONE: begin
        bus.out_valid = 1'b1;
        bus.busy      = 1'b1;
        bus.in_ready  = bus.out_ready;
      end
      default: bus.in_ready = 1'b0;
    endcase
  end

  // Sum of the current row group; rows past widthX-1 (short last group) are skipped.
  always_comb begin
    int idx;
    grp_sum = '0;
    for (int r = 0; r < rowsPerCycle; r++) begin
      idx = int'(cnt) * rowsPerCycle + r;
      if (idx < widthX) grp_sum = grp_sum + rows[idx*widthP +: widthP];
    end
  end

  // Datapath: capture, accumulate, group counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows <= '0;
      acc  <= '0;
      cnt  <= '0;
    end else if (take) begin
      rows <= bus.pp;
      acc  <= '0;
      cnt  <= '0;
    end else if (state == ACC) begin
      acc <= acc + grp_sum;
      cnt <= last_grp ? '0 : cnt + 1'b1;
    end
  end
endmodule
